// File: rtl/opb_apb_pkg.sv
// Shared types and defaults for the OPB-to-APB multi-slave bridge.
package opb_apb_pkg;

    localparam int unsigned ADDR_W_DEF  = 11;
    localparam int unsigned NUM_SLV_DEF = 4;
    localparam int unsigned SEL_LSB_DEF = 12;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

endpackage

// File: rtl/apb_slave_mux.sv
// Routes the addressed slave's PRDATA/PREADY/PSLVERR back to the bridge.
module apb_slave_mux
    import opb_apb_pkg::*;
#(
    parameter int unsigned NUM_SLV = NUM_SLV_DEF
) (
    input  logic [SEL_W-1:0]      idx,
    input  logic [NUM_SLV*32-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]    PREADY,
    input  logic [NUM_SLV-1:0]    PSLVERR,
    output logic [31:0]           sel_rdata,
    output logic                  sel_ready,
    output logic                  sel_slverr
);

    always_comb begin
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        for (int k = 0; k < int'(NUM_SLV); k++) begin
            if (idx == SEL_W'(k)) begin
                sel_rdata  = PRDATA[32*k +: 32];
                sel_ready  = PREADY[k];
                sel_slverr = PSLVERR[k];
            end
        end
    end

endmodule

// File: rtl/opb_apb_bridge_mc.sv
// OPB slave to multi-slave APB master bridge with wait-state timeout and
// error responses for unmapped slaves or conflicting requests.
module opb_apb_bridge_mc
    import opb_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned NUM_SLV = NUM_SLV_DEF,
    parameter int unsigned SEL_LSB = SEL_LSB_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  OPB_CLK,
    input  logic                  OPB_RST_N,
    input  logic [31:0]           OPB_ADDR,
    input  logic [31:0]           OPB_DI,
    input  logic                  OPB_WE,
    input  logic                  OPB_RE,
    output logic [31:0]           OPB_DO,
    output logic                  OPB_ACK,
    output logic                  OPB_ERR,
    output logic                  OPB_BUSY,
    output logic                  OPB_OVR,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [31:0]           PWDATA,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [NUM_SLV-1:0]    PSEL,
    input  logic [NUM_SLV*32-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]    PREADY,
    input  logic [NUM_SLV-1:0]    PSLVERR
);

    localparam logic [SEL_W:0] NumSlvL = (SEL_W + 1)'(NUM_SLV);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       do_q, do_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;

    logic [SEL_W-1:0]  req_idx;
    logic [31:0]       sel_rdata;
    logic              sel_ready;
    logic              sel_slverr;
    logic              unused_addr;

    assign req_idx     = OPB_ADDR[SEL_LSB +: SEL_W];
    assign unused_addr = ^OPB_ADDR;

    apb_slave_mux #(
        .NUM_SLV (NUM_SLV)
    ) u_mux (
        .idx        (idx_q),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .sel_rdata  (sel_rdata),
        .sel_ready  (sel_ready),
        .sel_slverr (sel_slverr)
    );

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        do_d     = do_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        // Requests arriving while a transfer is in flight are dropped but remembered.
        ovr_d    = ovr_q | ((state_q != StIdle) & (OPB_WE | OPB_RE));

        unique case (state_q)
            StIdle: begin
                if (OPB_WE && OPB_RE) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (OPB_WE || OPB_RE) begin
                    paddr_d  = OPB_ADDR[ADDR_W-1:0];
                    pwdata_d = OPB_DI;
                    pwrite_d = OPB_WE;
                    idx_d    = req_idx;
                    if ({1'b0, req_idx} >= NumSlvL) begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = StResp;
                        if (OPB_RE) do_d = '0;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                if (sel_ready) begin
                    ack_d   = 1'b1;
                    err_d   = sel_slverr;
                    state_d = StIdle;
                    if (!pwrite_q) do_d = sel_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This edge is the TIMEOUT-th wait edge: give up on the slave.
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (!pwrite_q) do_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state_q  <= StIdle;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            do_q     <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            do_q     <= do_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    // APB strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        PSEL = '0;
        if (state_q == StSetup || state_q == StAccess) begin
            for (int k = 0; k < int'(NUM_SLV); k++) begin
                PSEL[k] = (idx_q == SEL_W'(k));
            end
        end
    end

    assign PENABLE  = (state_q == StAccess);
    assign OPB_BUSY = (state_q != StIdle);
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign PWRITE   = pwrite_q;
    assign OPB_DO   = do_q;
    assign OPB_ACK  = ack_q;
    assign OPB_ERR  = err_q;
    assign OPB_OVR  = ovr_q;

endmodule

// File: tb/tb_opb_apb_bridge_mc.sv
// Scoreboard bench for opb_apb_bridge_mc: expected ACK latency, ERR and OPB_DO
// are queued at request time and checked when ACK appears.
module tb_opb_apb_bridge_mc;

    localparam int NS = 4;
    localparam int STUCK = 100000;

    logic              OPB_CLK = 1'b0;
    logic              OPB_RST_N = 1'b0;
    logic [31:0]       OPB_ADDR = '0;
    logic [31:0]       OPB_DI = '0;
    logic              OPB_WE = 1'b0;
    logic              OPB_RE = 1'b0;
    logic [31:0]       OPB_DO;
    logic              OPB_ACK, OPB_ERR, OPB_BUSY, OPB_OVR;
    logic [10:0]       PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE, PENABLE;
    logic [NS-1:0]     PSEL;
    logic [NS*32-1:0]  PRDATA;
    logic [NS-1:0]     PREADY, PSLVERR;

    opb_apb_bridge_mc dut (
        .OPB_CLK  (OPB_CLK),
        .OPB_RST_N(OPB_RST_N),
        .OPB_ADDR (OPB_ADDR),
        .OPB_DI   (OPB_DI),
        .OPB_WE   (OPB_WE),
        .OPB_RE   (OPB_RE),
        .OPB_DO   (OPB_DO),
        .OPB_ACK  (OPB_ACK),
        .OPB_ERR  (OPB_ERR),
        .OPB_BUSY (OPB_BUSY),
        .OPB_OVR  (OPB_OVR),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    int unsigned cyc = 0;
    always @(posedge OPB_CLK) cyc <= cyc + 1;

    // Slave models: PREADY rises after delay[k] wait cycles in ACCESS.
    int          delay [NS];
    logic [31:0] rdat  [NS];
    logic        serr  [NS];
    int          wcnt  [NS];

    always @(posedge OPB_CLK or negedge OPB_RST_N) begin
        for (int k = 0; k < NS; k++) begin
            if (!OPB_RST_N || !PENABLE) wcnt[k] <= 0;
            else if (PSEL[k] && !PREADY[k]) wcnt[k] <= wcnt[k] + 1;
        end
    end

    always_comb begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int k = 0; k < NS; k++) begin
            PREADY[k]          = PSEL[k] && PENABLE && (wcnt[k] >= delay[k]);
            PSLVERR[k]         = serr[k] && PREADY[k];
            PRDATA[32*k +: 32] = rdat[k];
        end
    end

    typedef struct {
        int unsigned n;
        int          lat;
        logic        err;
        logic        chk_do;
        logic [31:0] do_v;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge OPB_CLK) begin
        if (OPB_RST_N && OPB_ACK) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_latency", 64'(cyc - e.n + 1), 64'(e.lat));
                check("ack_err", 64'(OPB_ERR), 64'(e.err));
                if (e.chk_do) check("opb_do", 64'(OPB_DO), 64'(e.do_v));
            end
        end
    end

    // Call at a negedge; the request is sampled at the following posedge.
    task automatic issue(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] di, input int lat, input logic err,
                         input logic chk_do, input logic [31:0] do_v);
        exp_t e;
        OPB_WE   = we;
        OPB_RE   = re;
        OPB_ADDR = addr;
        OPB_DI   = di;
        e.n = cyc + 1; e.lat = lat; e.err = err; e.chk_do = chk_do; e.do_v = do_v;
        exp_q.push_back(e);
        @(posedge OPB_CLK);
        #1;
        OPB_WE = 1'b0;
        OPB_RE = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge OPB_CLK);
            #1;
            if (!OPB_BUSY && exp_q.size() == 0) break;
        end
        if (i == budget) begin
            check("wait_idle_budget", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        for (int k = 0; k < NS; k++) begin
            delay[k] = 0;
            rdat[k]  = 32'hA000_0000 + 32'(k);
            serr[k]  = 1'b0;
        end

        // Reset values
        #12;
        check("rst_ack", 64'(OPB_ACK), 64'd0);
        check("rst_err", 64'(OPB_ERR), 64'd0);
        check("rst_busy", 64'(OPB_BUSY), 64'd0);
        check("rst_ovr", 64'(OPB_OVR), 64'd0);
        check("rst_do", 64'(OPB_DO), 64'd0);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_pwrite", 64'(PWRITE), 64'd0);
        @(negedge OPB_CLK);
        OPB_RST_N = 1'b1;

        // Zero-wait write to slave 1
        @(negedge OPB_CLK);
        issue(1'b1, 1'b0, 32'h0000_1004, 32'h1234_5678, 3, 1'b0, 1'b1, 32'h0);
        @(negedge OPB_CLK);
        check("setup_psel", 64'(PSEL), 64'b0010);
        check("setup_penable", 64'(PENABLE), 64'd0);
        check("setup_paddr", 64'(PADDR), 64'h004);
        check("setup_pwdata", 64'(PWDATA), 64'h1234_5678);
        check("setup_pwrite", 64'(PWRITE), 64'd1);
        check("setup_busy", 64'(OPB_BUSY), 64'd1);
        @(negedge OPB_CLK);
        check("access_penable", 64'(PENABLE), 64'd1);
        check("access_psel", 64'(PSEL), 64'b0010);
        wait_idle(50);

        // Read slave 2 with five wait states
        delay[2] = 5;
        rdat[2]  = 32'hCAFE_F00D;
        @(negedge OPB_CLK);
        issue(1'b0, 1'b1, 32'h0000_27FF, 32'h0, 8, 1'b0, 1'b1, 32'hCAFE_F00D);
        @(negedge OPB_CLK);
        check("rd_paddr", 64'(PADDR), 64'h7FF);
        check("rd_pwrite", 64'(PWRITE), 64'd0);
        wait_idle(50);

        // Write must not touch OPB_DO
        @(negedge OPB_CLK);
        issue(1'b1, 1'b0, 32'h0000_1010, 32'hDEAD_BEEF, 3, 1'b0, 1'b1, 32'hCAFE_F00D);
        wait_idle(50);

        // Slave error on slave 3 write
        serr[3] = 1'b1;
        @(negedge OPB_CLK);
        issue(1'b1, 1'b0, 32'h0000_3020, 32'h0000_0001, 3, 1'b1, 1'b1, 32'hCAFE_F00D);
        wait_idle(50);

        // Unmapped slave index 5: write keeps DO, read clears it
        @(negedge OPB_CLK);
        issue(1'b1, 1'b0, 32'h0000_5000, 32'h0000_0055, 1, 1'b1, 1'b1, 32'hCAFE_F00D);
        @(negedge OPB_CLK);
        check("unmapped_psel", 64'(PSEL), 64'd0);
        check("unmapped_busy", 64'(OPB_BUSY), 64'd1);
        wait_idle(50);
        @(negedge OPB_CLK);
        issue(1'b0, 1'b1, 32'h0000_5000, 32'h0, 1, 1'b1, 1'b1, 32'h0);
        wait_idle(50);

        // Load DO, then conflicting WE+RE leaves it alone
        rdat[1] = 32'h1111_2222;
        @(negedge OPB_CLK);
        issue(1'b0, 1'b1, 32'h0000_1008, 32'h0, 3, 1'b0, 1'b1, 32'h1111_2222);
        wait_idle(50);
        @(negedge OPB_CLK);
        issue(1'b1, 1'b1, 32'h0000_1000, 32'h0, 1, 1'b1, 1'b1, 32'h1111_2222);
        @(negedge OPB_CLK);
        check("conflict_psel", 64'(PSEL), 64'd0);
        wait_idle(50);

        // Slave 0 stuck: timeout after 255 wait edges
        delay[0] = STUCK;
        @(negedge OPB_CLK);
        issue(1'b0, 1'b1, 32'h0000_0100, 32'h0, 257, 1'b1, 1'b1, 32'h0);
        wait_idle(400);
        check("timeout_psel", 64'(PSEL), 64'd0);

        // Request during ACCESS is dropped and flagged
        rdat[2] = 32'h5A5A_0002;
        @(negedge OPB_CLK);
        issue(1'b0, 1'b1, 32'h0000_2040, 32'h0, 8, 1'b0, 1'b1, 32'h5A5A_0002);
        @(negedge OPB_CLK);
        @(negedge OPB_CLK);
        OPB_WE = 1'b1; OPB_ADDR = 32'h0000_1234; OPB_DI = 32'hFFFF_FFFF;
        @(negedge OPB_CLK);
        OPB_WE = 1'b0;
        check("ovr_set", 64'(OPB_OVR), 64'd1);
        check("ovr_paddr", 64'(PADDR), 64'h040);
        check("ovr_pwrite", 64'(PWRITE), 64'd0);
        check("ovr_psel", 64'(PSEL), 64'b0100);
        wait_idle(50);

        // Back-to-back: new request in the ACK cycle
        @(negedge OPB_CLK);
        issue(1'b0, 1'b1, 32'h0000_1000, 32'h0, 3, 1'b0, 1'b1, 32'h1111_2222);
        begin
            int i;
            for (i = 0; i < 20; i++) begin
                @(negedge OPB_CLK);
                if (OPB_ACK) break;
            end
            if (i == 20) check("b2b_ack_seen", 64'd0, 64'd1);
        end
        issue(1'b1, 1'b0, 32'h0000_3000, 32'h0000_00AA, 3, 1'b1, 1'b1, 32'h1111_2222);
        wait_idle(50);
        check("ovr_sticky", 64'(OPB_OVR), 64'd1);

        // Reset during ACCESS aborts silently
        @(negedge OPB_CLK);
        issue(1'b0, 1'b1, 32'h0000_0004, 32'h0, 257, 1'b1, 1'b0, 32'h0);
        repeat (3) @(negedge OPB_CLK);
        check("pre_rst_penable", 64'(PENABLE), 64'd1);
        #2;
        OPB_RST_N = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_psel", 64'(PSEL), 64'd0);
        check("mid_rst_penable", 64'(PENABLE), 64'd0);
        check("mid_rst_busy", 64'(OPB_BUSY), 64'd0);
        check("mid_rst_ovr", 64'(OPB_OVR), 64'd0);
        check("mid_rst_do", 64'(OPB_DO), 64'd0);
        check("mid_rst_paddr", 64'(PADDR), 64'd0);
        check("mid_rst_ack", 64'(OPB_ACK), 64'd0);
        @(negedge OPB_CLK);
        OPB_RST_N = 1'b1;
        repeat (5) @(negedge OPB_CLK);

        // Recovery after reset
        delay[0] = 2;
        rdat[0]  = 32'h0BAD_CAFE;
        @(negedge OPB_CLK);
        issue(1'b0, 1'b1, 32'h0000_0008, 32'h0, 5, 1'b0, 1'b1, 32'h0BAD_CAFE);
        wait_idle(50);

        check("pending_expects", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/opb_apb_bridge_mc.md
OPB_APB_BRIDGE_MC -- requirements
Module: opb_apb_bridge_mc

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, APB address width.
REQ-002 SHALL have parameter NUM_SLV, default 4, number of APB slaves (1..16).
REQ-003 SHALL have parameter SEL_LSB, default 12, LSB of slave-index field OPB_ADDR[SEL_LSB +: 4].
REQ-004 SHALL have parameter TIMEOUT, default 255, max ACCESS wait cycles (1..65535).
REQ-005 SHALL have ports: OPB_CLK in 1 clock; OPB_RST_N in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: OPB_ADDR in 32; OPB_DI in 32; OPB_WE in 1; OPB_RE in 1 (single-cycle request pulses).
REQ-007 SHALL have ports: OPB_DO out 32 read data; OPB_ACK out 1 completion pulse; OPB_ERR out 1 error qualifier with ACK; OPB_BUSY out 1; OPB_OVR out 1 sticky dropped-request flag.
REQ-008 SHALL have ports: PADDR out ADDR_W; PWDATA out 32; PWRITE out 1; PENABLE out 1; PSEL out NUM_SLV one-hot.
REQ-009 SHALL have ports: PRDATA in NUM_SLV*32 (slave k at [32k +: 32]); PREADY in NUM_SLV; PSLVERR in NUM_SLV.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-011 In IDLE, exactly one of OPB_WE/OPB_RE high at edge N SHALL latch OPB_ADDR[ADDR_W-1:0] to PADDR, OPB_DI to PWDATA, WE to PWRITE, slave index, and enter SETUP.
REQ-012 SETUP (cycle after N) SHALL drive PSEL[idx]=1, PENABLE=0; next edge SHALL enter ACCESS with PENABLE=1.
REQ-013 In ACCESS, edge where PREADY[idx]=1 SHALL complete: PSEL/PENABLE to 0, OPB_ACK=1 for one cycle, OPB_ERR=PSLVERR[idx], return to IDLE; zero-wait slave gives ACK in cycle N+3.
REQ-014 Completed read SHALL register PRDATA[idx] into OPB_DO on the completing edge; OPB_DO SHALL hold until the next completed read or error.
REQ-015 Writes SHALL NOT modify OPB_DO.
REQ-016 ACCESS wait counter SHALL count edges with PREADY[idx]=0; on reaching TIMEOUT SHALL abort: PSEL/PENABLE to 0, ACK+ERR one cycle, OPB_DO=0 if read.
REQ-017 Slave index >= NUM_SLV SHALL skip APB (PSEL stays 0), go to RESP, and give ACK+ERR in cycle N+1, OPB_DO=0 if read.
REQ-018 OPB_WE and OPB_RE both high in IDLE SHALL go to RESP: ACK+ERR in cycle N+1, no APB transfer, OPB_DO unchanged.
REQ-019 OPB_BUSY SHALL be 1 in SETUP, ACCESS, RESP, else 0.
REQ-020 Any request while OPB_BUSY=1 SHALL be dropped, set OPB_OVR, and not disturb the transfer in progress.
REQ-021 PADDR, PWDATA, PWRITE SHALL stay stable from SETUP until completion.
REQ-022 Request in the cycle ACK is high (FSM in IDLE) SHALL be accepted normally (back-to-back).

Reset
REQ-023 OPB_RST_N low SHALL asynchronously force IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, OPB_DO=0, OPB_ACK=0, OPB_ERR=0, OPB_BUSY=0, OPB_OVR=0, wait counter=0.
REQ-024 Reset mid-transfer SHALL abort with no ACK; OPB_OVR clears only on reset.

Structure
REQ-025 Package opb_apb_pkg SHALL hold FSM state type, parameter defaults, and the slave-index field width (4).
REQ-026 Sub-module apb_slave_mux SHALL select PRDATA/PREADY/PSLVERR by latched index.

Verification
REQ-027 Write 0x0000_1004 data 0x1234_5678, slave 1 PREADY=1 -> PSEL=4'b0010, PADDR=0x004, ACK cycle N+3, ERR=0.
REQ-028 Read 0x0000_27FF, slave 2 PREADY low 5 cycles, PRDATA=0xCAFE_F00D -> PADDR=0x7FF, ACK cycle N+8, OPB_DO=0xCAFE_F00D.
REQ-029 Read slave 0 PREADY stuck low, TIMEOUT=255 -> abort after 255 wait cycles, ACK+ERR, OPB_DO=0.
REQ-030 Write 0x0000_5000 (idx 5, NUM_SLV=4) -> PSEL=0 throughout, ACK+ERR cycle N+1.
REQ-031 Second WE pulse during ACCESS -> dropped, OPB_OVR=1, first transfer completes unaltered.
REQ-032 OPB_RST_N low during ACCESS -> PSEL/PENABLE 0 immediately, no ACK, all outputs at reset values.
